uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds one UART transmitter from
// four byte requesters. Sequence per byte: IDLE (pick winner) -> ISSUE (one
// cycle start strobe + acceptance pulse) -> WAIT (hold byte until tx_done).
// Optional feature macro: UART_ARB_TIMEOUT_EN adds a WAIT watchdog that aborts
// the transfer after TIMEOUT_CYC cycles and pulses timeout_err.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  grant_q, grant_d;
    logic [7:0]  data_q, data_d;
    logic [3:0]  ready_q, ready_d;
    logic        start_q, start_d;

    // Configuration parameters are referenced here so the default build,
    // which has no watchdog, does not leave them dangling.
    logic unused_cfg;
    assign unused_cfg = (N_REQ == 0) ^ (TIMEOUT_CYC == 0);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;
`endif

    // Per-requester byte lanes.
    logic [7:0] req_byte [4];
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Round-robin pick: scan last+4 (== last) down to last+1 so the closest
    // valid requester after the last winner overwrites the others.
    logic       win_found;
    logic [1:0] win_idx;
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (req_valid[2'(last_q + 2'(k))]) begin
                win_found = 1'b1;
                win_idx   = 2'(last_q + 2'(k));
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        data_d  = data_q;
        ready_d = 4'b0000;
        start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = ISSUE;
                    grant_d = win_idx;
                    data_d  = req_byte[win_idx];
                    last_d  = win_idx;
                    start_d = 1'b1;
                    ready_d = 4'b0001 << win_idx;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (tx_done) begin
                    state_d = IDLE;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // This WAIT cycle brings the count to TIMEOUT_CYC.
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset overrides everything, tx_done included.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            grant_q <= 2'd0;
            data_q  <= 8'h00;
            ready_q <= 4'b0000;
            start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            start_q <= start_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign tx_start  = start_q;
    assign tx_data   = data_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed stimulus with a scoreboard queue of
// expected grants; a monitor pops one entry for every tx_start it observes.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;
    logic        txd;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0] gid;
        logic [7:0] data;
        logic [3:0] rdy;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [7:0] d);
        exp_q.push_back({g, d, 4'b0001 << g});
    endtask

    // Monitor: every start strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_start: got gid=%0d data=%02h expected none", grant_id, tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("grant_id", grant_id, mon_e.gid);
                    check("tx_data", tx_data, mon_e.data);
                    check("req_ready", req_ready, mon_e.rdy);
                    $display("XFER gid=%0d data=%02h ready=%b", grant_id, tx_data, req_ready);
                end
            end else if (req_ready != 4'b0000) begin
                check("ready_without_start", req_ready, 0);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait for tx_start; exp_gap is the negedge count expected from the call.
    task automatic wait_start(input int exp_gap);
        int k = 0;
        while (!tx_start && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!tx_start) check("start_timeout", 0, 1);
        else if (exp_gap >= 0) check("start_gap", k, exp_gap);
    endtask

    // Called at the negedge showing ISSUE; completes the transfer with tx_done.
    task automatic finish_xfer(input int wait_cyc, input bit drop, input bit clr);
        if (drop) req_valid = req_valid & ~req_ready;
        repeat (wait_cyc) @(negedge clk);
        check("wait_busy", busy, 1);
        check("wait_no_start", tx_start, 0);
        tx_done = 1'b1;
        if (clr) req_valid = 4'b0000;
        @(negedge clk);
        tx_done = 1'b0;
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] frame;
        logic [7:0] sh;
        logic       bitv;
        int         unstable;
        int         bad;

        reset     = 1'b1;
        tx_done   = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        txd       = 1'b1;
        frame     = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_req_ready", req_ready, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;

        // Two requesters, priority from requester 0 after reset.
        req_data  = {8'h00, 8'h3C, 8'h00, 8'hA5};
        push(2'd0, 8'hA5);
        push(2'd2, 8'h3C);
        req_valid = 4'b0101;
        wait_start(1);
        finish_xfer(3, 1'b1, 1'b0);
        wait_start(1);
        finish_xfer(3, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("idle_no_req", busy, 0);

        // All four held valid: rotation 0,1,2,3 twice, 2-cycle restart spacing.
        do_reset();
        req_data = 32'h44332211;
        for (int i = 0; i < 8; i++) push(2'(i), 8'(8'h11 * ((i % 4) + 1)));
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            wait_start(1);
            finish_xfer(2, 1'b0, i == 7);
        end

        // Serial model transmitter, 16 ticks per bit, byte 55 from requester 3.
        do_reset();
        req_data  = 32'h55000000;
        push(2'd3, 8'h55);
        req_valid = 4'b1000;
        wait_start(1);
        req_valid = 4'b0000;
        sh        = tx_data;
        unstable  = 0;
        for (int b = 0; b < 10; b++) begin
            bitv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : sh[b-1];
            for (int t = 0; t < 16; t++) begin
                @(negedge clk);
                txd = bitv;
                if (t == 7) frame[b] = txd;
                if (tx_data !== 8'h55 || grant_id !== 2'd3) unstable++;
            end
        end
        txd     = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("serial_frame", frame, 10'b1010101010);
        check("tx_data_stable", unstable, 0);
        check("idle_after_serial", busy, 0);

        // Reset 5 cycles into WAIT, then normal restart.
        req_data  = 32'h000000C3;
        push(2'd0, 8'hC3);
        push(2'd0, 8'hC3);
        req_valid = 4'b0001;
        wait_start(1);
        repeat (5) @(negedge clk);
        check("wait5_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_tx_start", tx_start, 0);
        check("midrst_grant_id", grant_id, 0);
        check("midrst_req_ready", req_ready, 0);
        reset = 1'b0;
        wait_start(1);
        finish_xfer(2, 1'b1, 1'b0);

        // Spurious tx_done in IDLE and in ISSUE.
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("spur_idle_busy", busy, 0);
        check("spur_idle_start", tx_start, 0);
        req_data  = 32'h00007700;
        push(2'd1, 8'h77);
        req_valid = 4'b0010;
        wait_start(1);
        req_valid = 4'b0000;
        tx_done   = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("spur_issue_wait", busy, 1);
        check("spur_issue_start", tx_start, 0);
        repeat (3) @(negedge clk);
        finish_xfer(1, 1'b0, 1'b0);

        // WAIT with no tx_done.
        req_data  = 32'h000000E1;
        push(2'd0, 8'hE1);
        req_valid = 4'b0001;
        wait_start(1);
        req_valid = 4'b0000;
        bad = 0;
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || timeout_err !== 1'b0) bad++;
        end
        check("timeout_wait_cycles", bad, 0);
        @(negedge clk);
        check("timeout_pulse", timeout_err, 1);
        check("timeout_idle", busy, 0);
        @(negedge clk);
        check("timeout_pulse_end", timeout_err, 0);
`else
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || timeout_err !== 1'b0) bad++;
        end
        check("no_timeout_hold", bad, 0);
        finish_xfer(1, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
